// File: rtl/simd_dispatch_arbiter_if.sv
// Dispatch/retire bundle between issue, the SIMD dispatch arbiter and the SIMD/ALU units.
// The master side is issue plus the SIMD units; the slave side is the arbiter.
interface simd_dispatch_arbiter_if #(
  parameter int unsigned NUM_SIMD = 4
);
  logic                  issue_valid;
  logic                  issue_halt;
  logic                  issue_ack;
  logic [NUM_SIMD-1:0]   simd_alu_ready;
  logic [NUM_SIMD-1:0]   simd_alu_select;
  logic [NUM_SIMD-1:0]   simd_instr_done;
  logic [6*NUM_SIMD-1:0] simd_instr_done_wfid;
  logic                  retire_valid;
  logic [5:0]            retire_wfid;
  logic [2:0]            retire_simd;
  logic                  idle;
  logic                  err_overflow;
  logic                  err_underflow;

  modport master (
    output issue_valid, issue_halt, simd_alu_ready, simd_instr_done, simd_instr_done_wfid,
    input  issue_ack, simd_alu_select, retire_valid, retire_wfid, retire_simd,
           idle, err_overflow, err_underflow
  );

  modport slave (
    input  issue_valid, issue_halt, simd_alu_ready, simd_instr_done, simd_instr_done_wfid,
    output issue_ack, simd_alu_select, retire_valid, retire_wfid, retire_simd,
           idle, err_overflow, err_underflow
  );
endinterface

// File: rtl/simd_dispatch_arbiter.sv
// Round-robin ALU dispatch across NUM_SIMD units with per-SIMD in-flight tracking
// and a round-robin merge of per-SIMD done FIFOs into one registered retire stream.
module simd_dispatch_arbiter #(
  parameter int unsigned NUM_SIMD     = 4,
  parameter int unsigned MAX_INFLIGHT = 2,
  parameter int unsigned DONE_DEPTH   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  simd_dispatch_arbiter_if.slave bus
);
  localparam int unsigned PW = $clog2(NUM_SIMD);
  localparam int unsigned AW = $clog2(DONE_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [PW-1:0] rr_ptr, ret_ptr;
  logic [2:0]    inflight     [NUM_SIMD];
  logic [2:0]    inflight_nxt [NUM_SIMD];
  logic [5:0]    fifo_mem     [NUM_SIMD][DONE_DEPTH];
  logic [AW-1:0] fifo_rp      [NUM_SIMD];
  logic [AW-1:0] fifo_wp      [NUM_SIMD];
  logic [CW-1:0] fifo_cnt     [NUM_SIMD];
  logic [CW-1:0] fifo_cnt_nxt [NUM_SIMD];

  logic [NUM_SIMD-1:0] elig, grant_oh, pop_oh, push_ok;
  logic                g_found, p_found, grant, ovf_ev, udf_ev, idle_nxt;
  logic [PW-1:0]       grant_idx, pop_idx;
  logic [5:0]          pop_wfid;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(NUM_SIMD - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    int unsigned idx;
    idx       = 0;
    elig      = '0;
    grant_oh  = '0;
    pop_oh    = '0;
    g_found   = 1'b0;
    p_found   = 1'b0;
    grant_idx = '0;
    pop_idx   = '0;
    for (int unsigned i = 0; i < NUM_SIMD; i++)
      elig[i] = bus.simd_alu_ready[i] && (inflight[i] < 3'(MAX_INFLIGHT));
    // Both searches start at their pointer and wrap at NUM_SIMD, not at 2**PW.
    for (int unsigned k = 0; k < NUM_SIMD; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= NUM_SIMD) idx = idx - NUM_SIMD;
      if (!g_found && elig[idx]) begin
        g_found   = 1'b1;
        grant_idx = PW'(idx);
      end
      idx = 32'(ret_ptr) + k;
      if (idx >= NUM_SIMD) idx = idx - NUM_SIMD;
      if (!p_found && (fifo_cnt[idx] != '0)) begin
        p_found = 1'b1;
        pop_idx = PW'(idx);
      end
    end
    grant             = g_found && bus.issue_valid && !bus.issue_halt;
    grant_oh[grant_idx] = grant;
    pop_oh[pop_idx]   = p_found;
  end

  assign bus.issue_ack = grant;
  assign pop_wfid      = fifo_mem[pop_idx][fifo_rp[pop_idx]];

  always_comb begin
    inflight_nxt = inflight;
    fifo_cnt_nxt = fifo_cnt;
    push_ok      = '0;
    ovf_ev       = 1'b0;
    udf_ev       = 1'b0;
    idle_nxt     = !p_found;
    for (int unsigned i = 0; i < NUM_SIMD; i++) begin
      if (grant_oh[i] && !bus.simd_instr_done[i])
        inflight_nxt[i] = inflight[i] + 3'd1;
      else if (!grant_oh[i] && bus.simd_instr_done[i]) begin
        if (inflight[i] == '0) udf_ev = 1'b1;
        else                   inflight_nxt[i] = inflight[i] - 3'd1;
      end
      // A full FIFO still accepts a push when it is popped in the same cycle.
      push_ok[i] = bus.simd_instr_done[i] && ((fifo_cnt[i] != CW'(DONE_DEPTH)) || pop_oh[i]);
      if (bus.simd_instr_done[i] && !push_ok[i]) ovf_ev = 1'b1;
      fifo_cnt_nxt[i] = fifo_cnt[i] + CW'(push_ok[i]) - CW'(pop_oh[i]);
      if ((inflight_nxt[i] != '0) || (fifo_cnt_nxt[i] != '0)) idle_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr            <= '0;
      ret_ptr           <= '0;
      bus.simd_alu_select <= '0;
      bus.retire_valid  <= 1'b0;
      bus.retire_wfid   <= '0;
      bus.retire_simd   <= '0;
      bus.idle          <= 1'b1;
      bus.err_overflow  <= 1'b0;
      bus.err_underflow <= 1'b0;
      for (int unsigned i = 0; i < NUM_SIMD; i++) begin
        inflight[i] <= '0;
        fifo_rp[i]  <= '0;
        fifo_wp[i]  <= '0;
        fifo_cnt[i] <= '0;
      end
    end else begin
      bus.simd_alu_select <= grant_oh;
      if (grant) rr_ptr <= wrap_inc(grant_idx);
      bus.retire_valid <= p_found;
      if (p_found) begin
        bus.retire_wfid <= pop_wfid;
        bus.retire_simd <= 3'(pop_idx);
        ret_ptr         <= wrap_inc(pop_idx);
      end
      bus.idle <= idle_nxt;
      if (ovf_ev) bus.err_overflow  <= 1'b1;
      if (udf_ev) bus.err_underflow <= 1'b1;
      for (int unsigned i = 0; i < NUM_SIMD; i++) begin
        inflight[i] <= inflight_nxt[i];
        fifo_cnt[i] <= fifo_cnt_nxt[i];
        if (push_ok[i]) begin
          fifo_mem[i][fifo_wp[i]] <= bus.simd_instr_done_wfid[6*i +: 6];
          fifo_wp[i]              <= fifo_wp[i] + AW'(1);
        end
        if (pop_oh[i]) fifo_rp[i] <= fifo_rp[i] + AW'(1);
      end
    end
  end
endmodule

// File: tb/tb_simd_dispatch_arbiter.sv
// Self-checking bench for simd_dispatch_arbiter: table-driven dispatch vectors plus
// hand-written retire/halt/overflow/reset sequences, with select and retire scoreboards.
module tb_simd_dispatch_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;

  simd_dispatch_arbiter_if #(.NUM_SIMD(4)) bus ();

  simd_dispatch_arbiter #(.NUM_SIMD(4), .MAX_INFLIGHT(2), .DONE_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  typedef struct {
    logic [3:0] ready;
    logic       valid;
    logic       halt;
    logic       exp_ack;
    logic [3:0] exp_sel;
  } vec_t;

  typedef struct {
    logic [5:0] wfid;
    logic [2:0] simd;
    int         due;
  } ret_t;

  vec_t       tbl[9];
  ret_t       rq[$];
  logic [3:0] sel_q[$];
  bit         ret_mon = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc_n);
  endtask

  // Negedge sampling: select scoreboard every cycle, retire scoreboard when enabled.
  task automatic sample();
    logic [3:0] es;
    ret_t       e;
    @(negedge clk);
    es = (sel_q.size() > 0) ? sel_q.pop_front() : 4'b0000;
    chk("select", 32'(bus.simd_alu_select), 32'(es));
    if (ret_mon) begin
      if (bus.retire_valid) begin
        if (rq.size() == 0) chk("retire_spurious", 32'(bus.retire_valid), 32'd0);
        else begin
          e = rq.pop_front();
          chk("retire_wfid", 32'(bus.retire_wfid), 32'(e.wfid));
          chk("retire_simd", 32'(bus.retire_simd), 32'(e.simd));
          chk("retire_cycle", cyc_n, e.due);
        end
      end else if (rq.size() > 0 && rq[0].due <= cyc_n) begin
        chk("retire_missing", 32'(bus.retire_valid), 32'd1);
        rq.delete(0);
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] ready, input logic valid, input logic halt,
                       input logic [3:0] done, input logic [23:0] wfid);
    bus.simd_alu_ready       = ready;
    bus.issue_valid          = valid;
    bus.issue_halt           = halt;
    bus.simd_instr_done      = done;
    bus.simd_instr_done_wfid = wfid;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(4'b0000, 1'b0, 1'b0, 4'b0000, 24'h0);
    sample();
    advance();
    rst = 1'b0;
    sel_q.delete();
    rq.delete();
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ack"}, 32'(bus.issue_ack), 32'd0);
    chk({tag, "_retire_valid"}, 32'(bus.retire_valid), 32'd0);
    chk({tag, "_retire_wfid"}, 32'(bus.retire_wfid), 32'd0);
    chk({tag, "_retire_simd"}, 32'(bus.retire_simd), 32'd0);
    chk({tag, "_idle"}, 32'(bus.idle), 32'd1);
    chk({tag, "_err_overflow"}, 32'(bus.err_overflow), 32'd0);
    chk({tag, "_err_underflow"}, 32'(bus.err_underflow), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    drive(v.ready, v.valid, v.halt, 4'b0000, 24'h0);
    sample();
    chk("ack", 32'(bus.issue_ack), 32'(v.exp_ack));
    if (v.exp_sel != 4'b0000) sel_q.push_back(v.exp_sel);
    advance();
  endtask

  task automatic idle_cycles(input int n);
    drive(4'b0000, 1'b0, 1'b0, 4'b0000, 24'h0);
    for (int i = 0; i < n; i++) begin
      sample();
      advance();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    logic [23:0] w;
    // Rotation across all-ready SIMDs from a fresh reset.
    tbl[0] = '{4'b1111, 1'b1, 1'b0, 1'b1, 4'b0001};
    tbl[1] = '{4'b1111, 1'b1, 1'b0, 1'b1, 4'b0010};
    tbl[2] = '{4'b1111, 1'b1, 1'b0, 1'b1, 4'b0100};
    tbl[3] = '{4'b1111, 1'b1, 1'b0, 1'b1, 4'b1000};
    // Only SIMD2 ready: MAX_INFLIGHT grants, then blocked.
    tbl[4] = '{4'b0100, 1'b1, 1'b0, 1'b1, 4'b0100};
    tbl[5] = '{4'b0100, 1'b1, 1'b0, 1'b1, 4'b0100};
    tbl[6] = '{4'b0100, 1'b1, 1'b0, 1'b0, 4'b0000};
    tbl[7] = '{4'b0100, 1'b1, 1'b0, 1'b0, 4'b0000};
    tbl[8] = '{4'b0100, 1'b1, 1'b1, 1'b0, 4'b0000};

    drive(4'b0000, 1'b0, 1'b0, 4'b0000, 24'h0);
    advance();
    do_reset();
    sample();
    chk_quiet("reset");
    advance();

    for (int i = 0; i < 4; i++) run_vec(tbl[i]);
    idle_cycles(1);

    do_reset();
    for (int i = 4; i < 9; i++) run_vec(tbl[i]);
    // Done on SIMD2 frees a slot; dispatch resumes once the count drops.
    w = 24'h0;
    w[17:12] = 6'd7;
    drive(4'b0100, 1'b0, 1'b0, 4'b0100, w);
    rq.push_back('{6'd7, 3'd2, cyc_n + 2});
    sample();
    advance();
    drive(4'b0100, 1'b1, 1'b0, 4'b0000, 24'h0);
    sample();
    chk("ack_resume", 32'(bus.issue_ack), 32'd1);
    sel_q.push_back(4'b0100);
    advance();
    sample();
    chk("ack_full_again", 32'(bus.issue_ack), 32'd0);
    advance();
    idle_cycles(3);

    // Simultaneous dones on SIMD0 and SIMD3 retire in pointer order.
    do_reset();
    w = 24'h0;
    w[5:0]   = 6'd5;
    w[23:18] = 6'd9;
    drive(4'b0000, 1'b0, 1'b0, 4'b1001, w);
    rq.push_back('{6'd5, 3'd0, cyc_n + 2});
    rq.push_back('{6'd9, 3'd3, cyc_n + 3});
    sample();
    advance();
    idle_cycles(4);
    chk("retire_q_empty_t3", 32'(rq.size()), 32'd0);

    // Halt blocks grants only; the pending done still drains and idle rises.
    do_reset();
    drive(4'b1111, 1'b1, 1'b0, 4'b0000, 24'h0);
    sample();
    chk("ack_pre_halt", 32'(bus.issue_ack), 32'd1);
    sel_q.push_back(4'b0001);
    advance();
    w = 24'h0;
    w[5:0] = 6'd12;
    drive(4'b1111, 1'b1, 1'b1, 4'b0001, w);
    rq.push_back('{6'd12, 3'd0, cyc_n + 2});
    sample();
    chk("ack_halted", 32'(bus.issue_ack), 32'd0);
    chk("idle_busy", 32'(bus.idle), 32'd0);
    advance();
    drive(4'b1111, 1'b1, 1'b1, 4'b0000, 24'h0);
    for (int i = 0; i < 8 && !bus.idle; i++) begin
      sample();
      chk("ack_halted_drain", 32'(bus.issue_ack), 32'd0);
      advance();
    end
    sample();
    chk("idle_drained", 32'(bus.idle), 32'd1);
    chk("retire_q_empty_t4", 32'(rq.size()), 32'd0);
    advance();

    // Flood every FIFO: overflow (and underflow, nothing in flight) go sticky.
    do_reset();
    ret_mon = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(4'b0000, 1'b0, 1'b0, 4'b1111, 24'($urandom));
      sample();
      advance();
    end
    idle_cycles(2);
    chk("err_overflow_set", 32'(bus.err_overflow), 32'd1);
    chk("err_underflow_flood", 32'(bus.err_underflow), 32'd1);
    idle_cycles(6);
    chk("err_overflow_sticky", 32'(bus.err_overflow), 32'd1);
    do_reset();
    sample();
    chk("err_overflow_cleared", 32'(bus.err_overflow), 32'd0);
    chk("err_underflow_cleared", 32'(bus.err_underflow), 32'd0);
    advance();
    drive(4'b0000, 1'b0, 1'b0, 4'b1000, 24'h0);
    sample();
    advance();
    idle_cycles(1);
    chk("err_underflow_set", 32'(bus.err_underflow), 32'd1);
    chk("err_overflow_clean", 32'(bus.err_overflow), 32'd0);

    // Reset mid-operation: every SIMD at MAX_INFLIGHT, FIFOs holding data.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(4'b1111, 1'b1, 1'b0, 4'b0000, 24'h0);
      sample();
      chk("ack_fill", 32'(bus.issue_ack), 32'd1);
      sel_q.push_back(4'(1 << (i % 4)));
      advance();
    end
    drive(4'b1111, 1'b0, 1'b0, 4'b0011, 24'h00_0A0B);
    sample();
    advance();
    do_reset();
    sample();
    chk_quiet("midreset");
    advance();
    drive(4'b1111, 1'b1, 1'b0, 4'b0000, 24'h0);
    sample();
    chk("ack_after_reset", 32'(bus.issue_ack), 32'd1);
    sel_q.push_back(4'b0001);
    advance();
    idle_cycles(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
